// File: rtl/pcs_64b66b_scram_pair_pkg.sv
// pcs_scram_pkg
//   Shared constants and types for the 64b/66b self-synchronising
//   scrambler pair (G(x) = 1 + x^39 + x^58).
//   SCRAM_W    : width of the scrambler history register
//   TAP_A/B    : polynomial tap distances, in bits back from the current bit
//   SCRAM_SEED : value loaded into the history register on reset
//   scram_state_t : history register type, [57] newest bit, [0] oldest
//   scram_mode_e  : selects scramble (TX) or descramble (RX) behaviour
package pcs_scram_pkg;

  localparam int SCRAM_W = 58;
  localparam int TAP_A   = 39;
  localparam int TAP_B   = 58;

  typedef logic [SCRAM_W-1:0] scram_state_t;

  localparam scram_state_t SCRAM_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic {
    SCRAMBLE   = 1'b0,
    DESCRAMBLE = 1'b1
  } scram_mode_e;

endpackage

// File: rtl/pcs_64b66b_scram_pair_if.sv
// pcs_64b66b_scram_pair_if
//   Slice bus between the PCS datapath and the scrambler pair.
//   valid_i    : TX slice valid, advances TX history
//   data_i     : TX plaintext slice (bit 0 first on the wire)
//   scram_o    : TX scrambled slice
//   rx_valid_i : RX slice valid, advances RX history
//   scram_i    : RX scrambled slice
//   data_o     : RX descrambled slice
//   modport master : the datapath side driving slices in
//   modport slave  : the scrambler pair
interface pcs_64b66b_scram_pair_if #(
  parameter int LEN = 32
);

  logic           valid_i;
  logic [LEN-1:0] data_i;
  logic [LEN-1:0] scram_o;
  logic           rx_valid_i;
  logic [LEN-1:0] scram_i;
  logic [LEN-1:0] data_o;

  modport master (
    output valid_i,
    output data_i,
    input  scram_o,
    output rx_valid_i,
    output scram_i,
    input  data_o
  );

  modport slave (
    input  valid_i,
    input  data_i,
    output scram_o,
    input  rx_valid_i,
    input  scram_i,
    output data_o
  );

endinterface

// File: rtl/pcs_64b66b_scram_pair_lane.sv
// pcs_scram_lane
//   One direction of the 64b/66b scrambler. Processes LEN bits per cycle,
//   output is combinational from din and the current history.
//   clk     : rising-edge clock
//   reset   : synchronous active-high, loads SCRAM_SEED
//   advance : shift this slice into the history at the next edge
//   din     : plaintext (SCRAMBLE) or scrambled (DESCRAMBLE) slice
//   dout    : scrambled (SCRAMBLE) or recovered (DESCRAMBLE) slice
module pcs_scram_lane
  import pcs_scram_pkg::*;
#(
  parameter scram_mode_e MODE = SCRAMBLE,
  parameter int          LEN  = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           advance,
  input  logic [LEN-1:0] din,
  output logic [LEN-1:0] dout
);

  scram_state_t state;

  // Unified wire history: [SCRAM_W-1:0] is the stored state (oldest at 0),
  // [SCRAM_W+i] is scrambled bit i of this slice. Bit i taps history
  // positions i+SCRAM_W-TAP_A and i+SCRAM_W-TAP_B, both strictly below
  // SCRAM_W+i, so the in-order loop only reads already-resolved bits.
  logic [SCRAM_W+LEN-1:0] hist;

  always_comb begin
    hist = {din, state};
    dout = '0;
    for (int i = 0; i < LEN; i++) begin
      dout[i] = din[i] ^ hist[SCRAM_W-TAP_A+i] ^ hist[SCRAM_W-TAP_B+i];
      // The scrambler feeds back its own output; the descrambler's history
      // is simply the received line bits already sitting in hist.
      if (MODE == SCRAMBLE) hist[SCRAM_W+i] = dout[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCRAM_SEED;
    end else if (advance) begin
      state <= hist[LEN +: SCRAM_W];
    end
  end

endmodule

// File: rtl/pcs_64b66b_scram_pair.sv
// pcs_64b66b_scram_pair
//   TX scrambler and RX descrambler for the 64b/66b PCS, sitting between
//   the block encoder/decoder and the gearbox. Sync headers bypass this
//   block. Both paths are zero-latency; history advances on valid.
//   clk   : rising-edge clock
//   reset : synchronous active-high, both histories return to all-ones
//   bus   : slice bus (slave modport), see pcs_64b66b_scram_pair_if
module pcs_64b66b_scram_pair
  import pcs_scram_pkg::*;
#(
  parameter int LEN = 32
) (
  input logic                  clk,
  input logic                  reset,
  pcs_64b66b_scram_pair_if.slave bus
);

  pcs_scram_lane #(
    .MODE (SCRAMBLE),
    .LEN  (LEN)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .advance (bus.valid_i),
    .din     (bus.data_i),
    .dout    (bus.scram_o)
  );

  pcs_scram_lane #(
    .MODE (DESCRAMBLE),
    .LEN  (LEN)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .advance (bus.rx_valid_i),
    .din     (bus.scram_i),
    .dout    (bus.data_o)
  );

endmodule

// File: tb/tb_pcs_64b66b_scram_pair.sv
module tb_pcs_64b66b_scram_pair;
  import pcs_scram_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pcs_64b66b_scram_pair_if #(.LEN(32)) bus32 ();
  pcs_64b66b_scram_pair_if #(.LEN(64)) bus64 ();

  pcs_64b66b_scram_pair #(.LEN(32)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  pcs_64b66b_scram_pair #(.LEN(64)) u_dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64.slave)
  );

  logic        loop_en = 1'b1;
  logic        drv_rx_valid = 1'b0;
  logic [31:0] drv_scram = '0;

  assign bus32.scram_i    = loop_en ? bus32.scram_o : drv_scram;
  assign bus32.rx_valid_i = loop_en ? bus32.valid_i : drv_rx_valid;
  assign bus64.scram_i    = bus64.scram_o;
  assign bus64.rx_valid_i = bus64.valid_i;

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] exp_q[$];
  logic [57:0] m_tx, m_rx, m_tx64;

  // Bit-serial reference: s[57] newest, taps at 39 and 58 bits back.
  task automatic scr_bits(input logic [57:0] s_in, input logic [63:0] d, input int n,
                          input bit descr, output logic [63:0] o, output logic [57:0] s_out);
    logic [57:0] s;
    logic b;
    s = s_in;
    o = '0;
    for (int i = 0; i < n; i++) begin
      b = d[i] ^ s[19] ^ s[0];
      o[i] = b;
      s = {descr ? d[i] : b, s[57:1]};
    end
    s_out = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus32.valid_i = 1'b0;
    bus64.valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_tx = SCRAM_SEED;
    m_rx = SCRAM_SEED;
    m_tx64 = SCRAM_SEED;
  endtask

  task automatic test_reset();
    logic [63:0] e, o;
    logic [57:0] ns;
    logic [31:0] d;
    loop_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    bus32.valid_i = 1'b0;
    bus64.valid_i = 1'b0;
    @(negedge clk);
    // state is seed: the low 39 bits of a slice pass straight through
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 32'hA5C3_0F96 : 32'h1234_5678;
      bus32.data_i = d;
      bus32.valid_i = 1'b1;  // reset must override valid
      bus64.data_i = 64'h0123_4567_89AB_CDEF;
      scr_bits(SCRAM_SEED, 64'h0123_4567_89AB_CDEF, 64, 1'b0, o, ns);
      exp_q.push_back({32'h0, d});
      exp_q.push_back({32'h0, d});
      exp_q.push_back(o);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.scram_o !== e[31:0]) begin
        n_mis++; $display("FAIL reset_scram_o[%0d]: got %h expected %h", k, bus32.scram_o, e[31:0]);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.data_o !== e[31:0]) begin
        n_mis++; $display("FAIL reset_data_o[%0d]: got %h expected %h", k, bus32.data_o, e[31:0]);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bus64.scram_o !== e) begin
        n_mis++; $display("FAIL reset_scram64[%0d]: got %h expected %h", k, bus64.scram_o, e);
      end
      @(negedge clk);
    end
    bus32.valid_i = 1'b0;
    bus64.valid_i = 1'b0;
    reset = 1'b0;
    m_tx = SCRAM_SEED;
    m_rx = SCRAM_SEED;
    m_tx64 = SCRAM_SEED;
  endtask

  task automatic run_vector(input string tag);
    logic [63:0] e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus32.valid_i = 1'b1;
      bus32.data_i = (k == 0) ? 32'h0000_001E : 32'h0000_0000;
      exp_q.push_back((k == 0) ? 64'h0000_001E : 64'h7BFF_F080);
      exp_q.push_back({32'h0, bus32.data_i});
      scr_bits(m_tx, {32'h0, bus32.data_i}, 32, 1'b0, e, m_tx);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.scram_o !== e[31:0]) begin
        n_mis++; $display("FAIL %s_scram_o[%0d]: got %h expected %h", tag, k, bus32.scram_o, e[31:0]);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.data_o !== e[31:0]) begin
        n_mis++; $display("FAIL %s_data_o[%0d]: got %h expected %h", tag, k, bus32.data_o, e[31:0]);
      end
    end
    @(negedge clk);
    bus32.valid_i = 1'b0;
  endtask

  task automatic test_vector();
    loop_en = 1'b1;
    do_reset();
    run_vector("vector");
  endtask

  task automatic test_len64();
    logic [63:0] e, o, d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d = (k == 0) ? 64'h1E : {$urandom, $urandom};
      bus64.valid_i = 1'b1;
      bus64.data_i = d;
      if (k == 0) exp_q.push_back(64'h7BFF_F080_0000_001E);
      else begin
        scr_bits(m_tx64, d, 64, 1'b0, o, m_tx64);
        exp_q.push_back(o);
      end
      if (k == 0) scr_bits(m_tx64, d, 64, 1'b0, o, m_tx64);
      exp_q.push_back(d);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus64.scram_o !== e) begin
        n_mis++; $display("FAIL len64_scram_o[%0d]: got %h expected %h", k, bus64.scram_o, e);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bus64.data_o !== e) begin
        n_mis++; $display("FAIL len64_data_o[%0d]: got %h expected %h", k, bus64.data_o, e);
      end
    end
    @(negedge clk);
    bus64.valid_i = 1'b0;
  endtask

  task automatic test_loopback();
    logic [63:0] e, o;
    logic [31:0] d;
    loop_en = 1'b1;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      d = $urandom;
      bus32.valid_i = 1'b1;
      bus32.data_i = d;
      scr_bits(m_tx, {32'h0, d}, 32, 1'b0, o, m_tx);
      exp_q.push_back(o);
      exp_q.push_back({32'h0, d});
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.scram_o !== e[31:0]) begin
        n_mis++; $display("FAIL loop_scram_o[%0d]: got %h expected %h", k, bus32.scram_o, e[31:0]);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.data_o !== e[31:0]) begin
        n_mis++; $display("FAIL loop_data_o[%0d]: got %h expected %h", k, bus32.data_o, e[31:0]);
      end
    end
    @(negedge clk);
    bus32.valid_i = 1'b0;
  endtask

  task automatic test_hold();
    logic [63:0] e, o;
    logic [57:0] ns;
    logic [31:0] d;
    loop_en = 1'b1;
    do_reset();
    @(negedge clk);
    bus32.valid_i = 1'b1;
    bus32.data_i = 32'h0000_001E;
    exp_q.push_back(64'h1E);
    scr_bits(m_tx, 64'h1E, 32, 1'b0, o, m_tx);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (bus32.scram_o !== e[31:0]) begin
      n_mis++; $display("FAIL hold_first: got %h expected %h", bus32.scram_o, e[31:0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d = $urandom;
      bus32.valid_i = 1'b0;
      bus32.data_i = d;
      scr_bits(m_tx, {32'h0, d}, 32, 1'b0, o, ns);  // state not advanced
      exp_q.push_back(o);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.scram_o !== e[31:0]) begin
        n_mis++; $display("FAIL hold_gap[%0d]: got %h expected %h", k, bus32.scram_o, e[31:0]);
      end
    end
    @(negedge clk);
    bus32.valid_i = 1'b1;
    bus32.data_i = 32'h0;
    exp_q.push_back(64'h7BFF_F080);
    #1;
    e = exp_q.pop_front(); n_cmp++;
    if (bus32.scram_o !== e[31:0]) begin
      n_mis++; $display("FAIL hold_resume: got %h expected %h", bus32.scram_o, e[31:0]);
    end
    @(negedge clk);
    bus32.valid_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [63:0] e, o;
    logic [31:0] d;
    loop_en = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d = $urandom;
      bus32.valid_i = 1'b1;
      bus32.data_i = d;
      scr_bits(m_tx, {32'h0, d}, 32, 1'b0, o, m_tx);
      exp_q.push_back(o);
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.scram_o !== e[31:0]) begin
        n_mis++; $display("FAIL midrst_pre[%0d]: got %h expected %h", k, bus32.scram_o, e[31:0]);
      end
    end
    do_reset();
    run_vector("midrst");
  endtask

  task automatic test_rx_resync();
    logic [63:0] e, o, r;
    logic [31:0] d;
    do_reset();
    loop_en = 1'b0;
    drv_rx_valid = 1'b0;
    // TX runs ahead alone so the RX history no longer matches it
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d = $urandom;
      bus32.valid_i = 1'b1;
      bus32.data_i = d;
      scr_bits(m_tx, {32'h0, d}, 32, 1'b0, o, m_tx);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      d = $urandom;
      bus32.valid_i = 1'b1;
      bus32.data_i = d;
      scr_bits(m_tx, {32'h0, d}, 32, 1'b0, o, m_tx);
      drv_scram = o[31:0];
      drv_rx_valid = 1'b1;
      scr_bits(m_rx, o, 32, 1'b1, r, m_rx);
      exp_q.push_back(o);
      exp_q.push_back(r);
      if (k >= 2) exp_q.push_back({32'h0, d});
      #1;
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.scram_o !== e[31:0]) begin
        n_mis++; $display("FAIL resync_scram_o[%0d]: got %h expected %h", k, bus32.scram_o, e[31:0]);
      end
      e = exp_q.pop_front(); n_cmp++;
      if (bus32.data_o !== e[31:0]) begin
        n_mis++; $display("FAIL resync_model[%0d]: got %h expected %h", k, bus32.data_o, e[31:0]);
      end
      if (k >= 2) begin
        e = exp_q.pop_front(); n_cmp++;
        if (bus32.data_o !== e[31:0]) begin
          n_mis++; $display("FAIL resync_plain[%0d]: got %h expected %h", k, bus32.data_o, e[31:0]);
        end
      end
    end
    @(negedge clk);
    bus32.valid_i = 1'b0;
    drv_rx_valid = 1'b0;
    loop_en = 1'b1;
  endtask

  initial begin
    bus32.valid_i = 1'b0;
    bus32.data_i = '0;
    bus64.valid_i = 1'b0;
    bus64.data_i = '0;
    m_tx = SCRAM_SEED;
    m_rx = SCRAM_SEED;
    m_tx64 = SCRAM_SEED;
    test_reset();
    test_vector();
    test_len64();
    test_loopback();
    test_hold();
    test_mid_reset();
    test_rx_resync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
